// File: rtl/id_ex_stage_buf.sv
// rtl/id_ex_stage_buf.sv - elastic ID/EX pipeline stage with a 2-entry skid buffer and flush
//
// Optional feature macro: ID_EX_STAGE_BUF_PERF_CNT_EN (backpressure stall counter)
//
// Ports:
//   clk        in   1       clock, all state updates on posedge
//   rstn       in   1       synchronous active-low reset
//   in_valid   in   1       decode presents an instruction
//   in_ready   out  1       stage can accept (registered, low only when FULL)
//   in_data    in   DATA_W  payload (dest, store value, val1, val2, PC)
//   in_ctrl    in   CTRL_W  control vector, all-zero is NOP
//   in_src     in   SRC_W   source register tags for forwarding
//   flush      in   1       discard all held and incoming entries
//   out_valid  out  1       execute-side entry valid
//   out_ready  in   1       execute consumes the head entry
//   out_data   out  DATA_W  head payload, holds last value in bubbles
//   out_ctrl   out  CTRL_W  head control, 0 in bubbles
//   out_src    out  SRC_W   head source tags, 0 in bubbles
//   occupancy  out  2       entries held (0..2)
//   stall_cnt  out  CNT_W   saturating count of out_valid && !out_ready cycles

module id_ex_stage_buf #(
    parameter int DATA_W = 133,
    parameter int CTRL_W = 8,
    parameter int SRC_W  = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [SRC_W-1:0]  in_src,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [SRC_W-1:0]  out_src,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;

    // The main register is the head and drives out_* directly, so the
    // output ports are plain flops with no path from in_*.
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [SRC_W-1:0]  main_src;

    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [SRC_W-1:0]  skid_src;

    logic              accept;
    logic              consume;

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    assign out_data = main_data;
    assign out_ctrl = main_ctrl;
    assign out_src  = main_src;

    // main_ctrl/main_src are cleared whenever the stage goes empty, which
    // keeps bubbles as NOPs without a mux on the outputs; main_data is left
    // alone so out_data holds its last value.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
            main_data <= '0;
            main_ctrl <= '0;
            main_src  <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
            skid_src  <= '0;
        end else if (flush) begin
            // A same-cycle consume already completed downstream; only the
            // held entries and any incoming accept are dropped here.
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
            main_ctrl <= '0;
            main_src  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                        main_src  <= in_src;
                        state     <= ONE;
                        out_valid <= 1'b1;
                        occupancy <= 2'd1;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                        main_src  <= in_src;
                    end else if (accept) begin
                        // Head is stalled; park the newcomer behind it.
                        skid_data <= in_data;
                        skid_ctrl <= in_ctrl;
                        skid_src  <= in_src;
                        state     <= FULL;
                        in_ready  <= 1'b0;
                        occupancy <= 2'd2;
                    end else if (consume) begin
                        main_ctrl <= '0;
                        main_src  <= '0;
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                        occupancy <= 2'd0;
                    end
                end
                FULL: begin
                    if (consume) begin
                        main_data <= skid_data;
                        main_ctrl <= skid_ctrl;
                        main_src  <= skid_src;
                        state     <= ONE;
                        in_ready  <= 1'b1;
                        occupancy <= 2'd1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    occupancy <= 2'd0;
                    main_ctrl <= '0;
                    main_src  <= '0;
                end
            endcase
        end
    end

`ifdef ID_EX_STAGE_BUF_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;

    // Flush deliberately leaves the count alone; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_buf.sv
// tb/tb_id_ex_stage_buf.sv - scoreboard testbench for id_ex_stage_buf
module tb_id_ex_stage_buf;

    localparam int DATA_W = 133;
    localparam int CTRL_W = 8;
    localparam int SRC_W  = 10;
`ifdef ID_EX_STAGE_BUF_PERF_CNT_EN
    localparam int CNT_W  = 2;
`else
    localparam int CNT_W  = 16;
`endif

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
        logic [SRC_W-1:0]  s;
    } ent_t;

    logic              clk = 1'b0;
    logic              rstn;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic [SRC_W-1:0]  in_src;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [SRC_W-1:0]  out_src;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    id_ex_stage_buf #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .SRC_W(SRC_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_src(in_src),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_src(out_src),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    ent_t              sb[$];
    logic [DATA_W-1:0] last_data;
    int                m_stall;
    int                stall_max;

    task automatic check(input string tag, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Called just after a negedge with inputs set for the coming posedge:
    // compare outputs against the scoreboard, then advance the model.
    task automatic tick();
        logic m_ready, m_valid, acc, con;
        ent_t e;
        m_valid = (sb.size() > 0);
        m_ready = (sb.size() < 2);
        check("in_ready", {159'd0, in_ready}, {159'd0, m_ready});
        check("out_valid", {159'd0, out_valid}, {159'd0, m_valid});
        check("occupancy", {158'd0, occupancy}, 160'(sb.size()));
        check("stall_cnt", 160'(stall_cnt), 160'(m_stall));
        if (m_valid) begin
            check("out_data", 160'(out_data), 160'(sb[0].d));
            check("out_ctrl", 160'(out_ctrl), 160'(sb[0].c));
            check("out_src", 160'(out_src), 160'(sb[0].s));
        end else begin
            check("bubble_data", 160'(out_data), 160'(last_data));
            check("bubble_ctrl", 160'(out_ctrl), 160'd0);
            check("bubble_src", 160'(out_src), 160'd0);
        end
        acc = in_valid && m_ready;
        con = m_valid && out_ready;
`ifdef ID_EX_STAGE_BUF_PERF_CNT_EN
        if (m_valid && !out_ready && m_stall < stall_max) m_stall++;
`endif
        if (con) void'(sb.pop_front());
        if (flush) begin
            sb.delete();
        end else if (acc) begin
            e.d = in_data; e.c = in_ctrl; e.s = in_src;
            sb.push_back(e);
        end
        if (sb.size() > 0) last_data = sb[0].d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                         input logic [SRC_W-1:0] s, input logic ordy, input logic fl);
        in_valid = v; in_data = d; in_ctrl = c; in_src = s;
        out_ready = ordy; flush = fl;
        tick();
    endtask

    task automatic do_reset();
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        in_data = '1; in_ctrl = '1; in_src = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {159'd0, out_valid}, 160'd0);
        check("rst_out_ctrl", 160'(out_ctrl), 160'd0);
        check("rst_out_src", 160'(out_src), 160'd0);
        check("rst_out_data", 160'(out_data), 160'd0);
        check("rst_occupancy", {158'd0, occupancy}, 160'd0);
        check("rst_stall_cnt", 160'(stall_cnt), 160'd0);
        sb.delete();
        last_data = '0;
        m_stall = 0;
        rstn = 1'b1;
    endtask

    initial begin
        logic [159:0] r;
        stall_max = (1 << CNT_W) - 1;
        do_reset();

        // streaming at full rate
        for (int i = 1; i <= 4; i++)
            drive(1'b1, DATA_W'(i), CTRL_W'(8'h80 | i), SRC_W'(i * 3), 1'b1, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);

        // backpressure: A, B fill the stage, C waits until in_ready returns
        drive(1'b1, DATA_W'(8'hA), 8'h1A, 10'h0A, 1'b0, 1'b0);
        drive(1'b1, DATA_W'(8'hB), 8'h1B, 10'h0B, 1'b0, 1'b0);
        drive(1'b1, DATA_W'(8'hC), 8'h1C, 10'h0C, 1'b0, 1'b0);
        drive(1'b1, DATA_W'(8'hC), 8'h1C, 10'h0C, 1'b0, 1'b0);
        drive(1'b1, DATA_W'(8'hC), 8'h1C, 10'h0C, 1'b1, 1'b0);
        drive(1'b1, DATA_W'(8'hC), 8'h1C, 10'h0C, 1'b1, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);

        // flush while FULL with a new instruction offered
        drive(1'b1, DATA_W'(8'h51), 8'h21, 10'h11, 1'b0, 1'b0);
        drive(1'b1, DATA_W'(8'h52), 8'h22, 10'h12, 1'b0, 1'b0);
        drive(1'b1, DATA_W'(8'h53), 8'h23, 10'h13, 1'b0, 1'b1);
        // bubbles after the flush
        for (int i = 0; i < 3; i++) drive(1'b0, '1, '1, '1, 1'b1, 1'b0);

        // flush in ONE with a same-cycle consume and accept
        drive(1'b1, DATA_W'(8'h61), 8'h31, 10'h21, 1'b1, 1'b0);
        drive(1'b1, DATA_W'(8'h62), 8'h32, 10'h22, 1'b1, 1'b1);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);

        // stall counting, then flush, then reset
        drive(1'b1, DATA_W'(8'h71), 8'h41, 10'h31, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b1);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        do_reset();
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom, $urandom};
            drive(($urandom_range(0, 3) != 0), r[DATA_W-1:0], CTRL_W'($urandom),
                  SRC_W'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
        end

        // reset while FULL discards everything
        drive(1'b1, DATA_W'(8'h81), 8'h51, 10'h41, 1'b0, 1'b0);
        drive(1'b1, DATA_W'(8'h82), 8'h52, 10'h42, 1'b0, 1'b0);
        drive(1'b1, DATA_W'(8'h83), 8'h53, 10'h43, 1'b0, 1'b0);
        do_reset();
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_buf.md
Name: id_ex_stage_buf

Overview:
- Parametrised, elastic successor to the ID/EX pipeline register.
- Carries an opaque payload (operands, PC, dest/src indices) plus a control vector (WB/MEM enables, EXE command, branch-taken) from decode to execute.
- Adds a valid/ready handshake with a 2-entry skid buffer, so backpressure never drops or duplicates an instruction, plus a synchronous flush for branch redirects.
- Bubbles always present all-zero control (NOP).

Parameters:
- DATA_W, 133, payload width in bits (dest 5 + store value 32 + val1 32 + val2 32 + PC 32).
- CTRL_W, 8, control vector width in bits; all-zero encodes NOP.
- SRC_W, 10, forwarding tag width in bits (src1 5 + src2 5); travels with the entry.
- CNT_W, 16, stall counter width in bits (used only with PERF_CNT_EN).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rstn  in  1  reset, synchronous, active-low.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept; registered, equals !(state==FULL).
- in_data  in  DATA_W  payload.
- in_ctrl  in  CTRL_W  control vector.
- in_src  in  SRC_W  source register tags.
- flush  in  1  discard all held and incoming entries.
- out_valid  out  1  execute-side entry valid.
- out_ready  in  1  execute consumes the entry.
- out_data  out  DATA_W  head payload.
- out_ctrl  out  CTRL_W  head control; forced 0 when out_valid=0.
- out_src  out  SRC_W  head source tags; forced 0 when out_valid=0.
- occupancy  out  2  entries held (0..2).
- stall_cnt  out  CNT_W  backpressure cycle count (PERF_CNT_EN only, else tied 0).

Behaviour:
- Storage: a main register (head, drives the out_* ports) and a skid register.
- State machine: EMPTY (0 entries), ONE (main only), FULL (main and skid).
- Handshakes: accept = in_valid && in_ready; consume = out_valid && out_ready.
- out_valid = (state != EMPTY). occupancy = 0/1/2 for EMPTY/ONE/FULL.
- Latency: an entry accepted in cycle N appears on out_* in cycle N+1 when the stage was EMPTY, or when it was ONE and consumed in the same cycle. There is no combinational path from in_* to out_*.
- EMPTY: accept -> main <= in, go to ONE.
- ONE:
  - accept && consume -> main <= in, stay in ONE.
  - accept && !consume -> skid <= in, go to FULL.
  - !accept && consume -> go to EMPTY.
  - else hold.
- FULL: in_ready=0, so no accept is possible.
  - consume -> main <= skid, go to ONE.
  - else hold.
- Ordering is strictly FIFO; the head is never overwritten while out_valid && !out_ready.
- Flush (highest priority after reset):
  - Next state is EMPTY; any same-cycle accept is discarded.
  - A same-cycle consume still completes downstream; the stage does not retract it.
  - in_ready is 1 in the following cycle.
- Bubble: when out_valid=0, out_ctrl and out_src are 0. out_data holds its last value, or 0 after reset.
- Reset (rstn=0 at a posedge):
  - state EMPTY; main, skid, out_data, out_ctrl and out_src all 0.
  - out_valid=0, occupancy=0, stall_cnt=0.
  - in_ready=1 in the first cycle after reset is released.
  - Reset mid-operation discards all entries with no partial output.
- The in_* ports are only sampled on accept. Changes while in_ready=0 have no effect.

Optional Feature:
- Macro: ID_EX_STAGE_BUF_PERF_CNT_EN.
- Defined:
  - stall_cnt increments by 1 each cycle with out_valid && !out_ready.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset; flush does not clear it.
- Undefined:
  - No counter logic is built; stall_cnt is tied to 0.
  - All other behaviour is identical.

Test Plan:
- Reset with rstn=0 for 2 cycles -> out_valid=0, out_ctrl=0, occupancy=0, stall_cnt=0; in_ready=1 in the cycle after release.
- Streaming: out_ready=1, feed in_data=1,2,3,4 on consecutive cycles -> out_data=1,2,3,4 one cycle later each, occupancy stays 1, in_ready stays 1.
- Backpressure: accept A=0xA then B=0xB with out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA held. Offered C is ignored. Raise out_ready -> outputs A, then B, then C (after in_ready returns to 1), with no loss or duplication.
- Flush in FULL with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; the flushed and incoming entries never appear on the outputs.
- Bubble: in_valid=0 for 3 cycles after draining -> out_ctrl=0 and out_src=0 each cycle, out_data holds its last value.
- With ID_EX_STAGE_BUF_PERF_CNT_EN and CNT_W=2: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=1,2,3,3,3. A flush then leaves stall_cnt=3; reset clears it to 0.
